// File: rtl/lab2_proc_imul_arbiter_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
// No logic; imported by the grant scan and the arbiter top.
// Request is {a, b}, response is the low 32 bits of the product.
package lab2_proc_imul_arbiter_pkg;

  localparam int c_imul_req_nbits  = 64;
  localparam int c_imul_resp_nbits = 32;

  typedef enum logic {
    IMUL_ARB_IDLE = 1'b0,
    IMUL_ARB_BUSY = 1'b1
  } imul_arb_state_e;

endpackage

// File: rtl/lab2_proc_imul_rr_grant.sv
// Round-robin priority scan: first valid requester after 'last', wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller qualifies the grant with ready.
module lab2_proc_imul_rr_grant #(
  parameter int p_num_reqs  = 2,
  parameter int p_idx_nbits = 1
) (
  input  logic [p_num_reqs-1:0]  req_val,
  input  logic [p_idx_nbits-1:0] last,
  output logic [p_idx_nbits-1:0] grant_idx,
  output logic                   grant_any
);

  logic [p_idx_nbits-1:0] cand;

  // Scan last+1 .. last+p_num_reqs (mod p_num_reqs); the first hit wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= p_num_reqs; k++) begin
      cand = p_idx_nbits'((int'(last) + k) % p_num_reqs);
      if (!grant_any && req_val[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lab2_proc_imul_arbiter.sv
// Shares one iterative multiplier among p_num_reqs val/rdy requesters, round-robin.
// Latency: zero added cycles; request and response paths are combinational muxes.
// Backpressure: one op in flight; an owner holding resp_rdy low stalls everyone.
// Optional counters stat_issues / stat_stall_cycles: LAB2_PROC_IMUL_ARBITER_STATS_EN.
module lab2_proc_imul_arbiter
  import lab2_proc_imul_arbiter_pkg::*;
#(
  parameter int p_num_reqs = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [p_num_reqs-1:0]                  req_val,
  output logic [p_num_reqs-1:0]                  req_rdy,
  input  logic [c_imul_req_nbits*p_num_reqs-1:0] req_msg,
  output logic [p_num_reqs-1:0]                  resp_val,
  input  logic [p_num_reqs-1:0]                  resp_rdy,
  output logic [c_imul_resp_nbits-1:0]           resp_msg,
  output logic                                   mul_req_val,
  input  logic                                   mul_req_rdy,
  output logic [c_imul_req_nbits-1:0]            mul_req_msg,
  input  logic                                   mul_resp_val,
  output logic                                   mul_resp_rdy,
  input  logic [c_imul_resp_nbits-1:0]           mul_resp_msg
`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
  ,
  output logic [31:0]                            stat_issues,
  output logic [31:0]                            stat_stall_cycles
`endif
);

  localparam int c_idx_nbits = $clog2(p_num_reqs);

  imul_arb_state_e        state, state_next;
  logic [c_idx_nbits-1:0] last, owner, grant_idx;
  logic                   grant_any;
  logic                   issue_fire, resp_fire;

  lab2_proc_imul_rr_grant #(
    .p_num_reqs  (p_num_reqs),
    .p_idx_nbits (c_idx_nbits)
  ) u_grant (
    .req_val   (req_val),
    .last      (last),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // State, last winner and owner; the winner is recorded at issue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IMUL_ARB_IDLE;
      last  <= c_idx_nbits'(p_num_reqs - 1);
      owner <= '0;
    end else begin
      state <= state_next;
      if (issue_fire) begin
        owner <= grant_idx;
        last  <= grant_idx;
      end
    end
  end

  // Next state and handshake muxing; all handshakes forced low while in reset.
  always_comb begin
    state_next   = state;
    req_rdy      = '0;
    resp_val     = '0;
    mul_req_val  = 1'b0;
    mul_req_msg  = '0;
    mul_resp_rdy = 1'b0;
    resp_msg     = mul_resp_msg;
    issue_fire   = 1'b0;
    resp_fire    = 1'b0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (grant_idx == c_idx_nbits'(i)) begin
        mul_req_msg = req_msg[i*c_imul_req_nbits +: c_imul_req_nbits];
      end
    end
    case (state)
      IMUL_ARB_IDLE: begin
        mul_req_val        = grant_any;
        req_rdy[grant_idx] = grant_any & mul_req_rdy;
        issue_fire         = grant_any & mul_req_rdy;
        if (issue_fire) state_next = IMUL_ARB_BUSY;
      end
      IMUL_ARB_BUSY: begin
        resp_val[owner] = mul_resp_val;
        mul_resp_rdy    = resp_rdy[owner];
        resp_fire       = mul_resp_val & resp_rdy[owner];
        if (resp_fire) state_next = IMUL_ARB_IDLE;
      end
      default: state_next = IMUL_ARB_IDLE;
    endcase
    if (!reset) begin
      req_rdy      = '0;
      resp_val     = '0;
      mul_req_val  = 1'b0;
      mul_resp_rdy = 1'b0;
      issue_fire   = 1'b0;
    end
  end

`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
  // Issue count and cycles in which some requester is valid but not ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_issues       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (issue_fire) stat_issues <= stat_issues + 32'd1;
      if (|(req_val & ~req_rdy)) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lab2_proc_imul_arbiter.sv
// Bench for lab2_proc_imul_arbiter: two-requester DUT with a mock multiplier,
// plus a four-requester DUT driven by hand for the wrap-around scan.
// Expected responses are queued at drive time and checked as responses fire.
module tb_lab2_proc_imul_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_val, req_rdy, resp_val, resp_rdy;
  logic [64*N-1:0] req_msg;
  logic [31:0]     resp_msg;
  logic            mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
  logic [63:0]     mul_req_msg;
  logic [31:0]     mul_resp_msg;
`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
  logic [31:0]     stat_issues, stat_stall_cycles;
`endif

  logic [3:0]      q4_req_val, q4_req_rdy, q4_resp_val, q4_resp_rdy;
  logic [255:0]    q4_req_msg;
  logic [31:0]     q4_resp_msg, q4_mul_resp_msg;
  logic            q4_mul_req_val, q4_mul_req_rdy, q4_mul_resp_val, q4_mul_resp_rdy;
  logic [63:0]     q4_mul_req_msg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_resp_cyc = -100;

  typedef struct {
    int          owner;
    logic [31:0] prod;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lab2_proc_imul_arbiter #(.p_num_reqs(N)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg)
`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
    , .stat_issues(stat_issues), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  lab2_proc_imul_arbiter #(.p_num_reqs(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_val(q4_req_val), .req_rdy(q4_req_rdy), .req_msg(q4_req_msg),
    .resp_val(q4_resp_val), .resp_rdy(q4_resp_rdy), .resp_msg(q4_resp_msg),
    .mul_req_val(q4_mul_req_val), .mul_req_rdy(q4_mul_req_rdy), .mul_req_msg(q4_mul_req_msg),
    .mul_resp_val(q4_mul_resp_val), .mul_resp_rdy(q4_mul_resp_rdy), .mul_resp_msg(q4_mul_resp_msg)
`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
    , .stat_issues(), .stat_stall_cycles()
`endif
  );

  // Mock iterative multiplier: one op at a time, fixed latency, holds result until taken.
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_prod = '0;
  assign mul_req_rdy  = !m_busy;
  assign mul_resp_val = m_busy && (m_cnt == 0);
  assign mul_resp_msg = m_prod;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (mul_req_val) begin
        m_busy <= 1'b1;
        m_cnt  <= 3;
        m_prod <= mul_req_msg[63:32] * mul_req_msg[31:0];
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end else if (mul_resp_rdy) begin
      m_busy <= 1'b0;
    end
  end

  // Response scoreboard: routing must match the queued owner, product on fire.
  always @(negedge clk) begin
    logic [N-1:0] oh;
    if (reset === 1'b1 && (|resp_val)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: resp_val=%b with nothing outstanding", resp_val);
      end else begin
        oh = '0;
        oh[exp_q[0].owner] = 1'b1;
        if (resp_val !== oh) begin
          n_fail++;
          $display("FAIL resp_route: resp_val=%b expected %b", resp_val, oh);
        end
        if (|(resp_val & resp_rdy)) begin
          n_checks++;
          if (resp_msg !== exp_q[0].prod) begin
            n_fail++;
            $display("FAIL resp_msg: got %0d expected %0d", resp_msg, exp_q[0].prod);
          end
          void'(exp_q.pop_front());
          last_resp_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int owner, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.owner = owner;
    e.prod  = a * b;
    exp_q.push_back(e);
  endtask

  task automatic wait_issue(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_val[r] && req_rdy[r]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset;
    step();
    reset = 1'b0;
    req_val = '0; resp_rdy = '0; req_msg = '0;
    q4_req_val = '0; q4_resp_rdy = '0; q4_req_msg = '0;
    q4_mul_req_rdy = 1'b0; q4_mul_resp_val = 1'b0; q4_mul_resp_msg = '0;
    exp_q.delete();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req_val = 2'b11; resp_rdy = 2'b11; req_msg = '1;
    q4_req_val = 4'hF; q4_resp_rdy = 4'hF; q4_req_msg = '1;
    q4_mul_req_rdy = 1'b1; q4_mul_resp_val = 1'b1; q4_mul_resp_msg = '0;
    step(); step();
    @(negedge clk);
    n_checks++;
    if ({req_rdy, resp_val, mul_req_val, mul_resp_rdy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {req_rdy, resp_val, mul_req_val, mul_resp_rdy});
    end
    n_checks++;
    if ({q4_req_rdy, q4_resp_val, q4_mul_req_val, q4_mul_resp_rdy} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs4: got %b expected 0",
               {q4_req_rdy, q4_resp_val, q4_mul_req_val, q4_mul_resp_rdy});
    end
    apply_reset();
    @(negedge clk);
    n_checks++;
    if (mul_req_val !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: mul_req_val=%b expected 0", mul_req_val);
    end
  endtask

  task automatic test_single;
    bit ok, quiet;
    apply_reset();
    resp_rdy = 2'b11;
    req_msg[63:0] = {32'd7, 32'd6};
    req_val = 2'b01;
    push_exp(0, 32'd7, 32'd6);
    wait_issue(0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_issue: req_rdy[0]=%b expected 1 within bound", req_rdy[0]);
    end
    n_checks++;
    if (mul_req_msg !== {32'd7, 32'd6}) begin
      n_fail++;
      $display("FAIL single_msg: mul_req_msg=%h expected %h", mul_req_msg, {32'd7, 32'd6});
    end
    step();
    req_val = 2'b00;
    quiet = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_val[1] !== 1'b0) quiet = 1'b0;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL single_resp1_quiet: resp_val[1] went 1, expected 0 throughout");
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_rr;
    logic [31:0] a[2][2];
    logic [31:0] b[2][2];
    int k[2];
    int order[4] = '{0, 1, 0, 1};
    int n_iss;
    bit ok;
    apply_reset();
    resp_rdy = 2'b11;
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 2; j++) begin
        a[r][j] = $urandom;
        b[r][j] = $urandom;
      end
    for (int j = 0; j < 4; j++) push_exp(order[j], a[order[j]][j/2], b[order[j]][j/2]);
    k[0] = 0; k[1] = 0; n_iss = 0;
    req_msg[63:0]   = {a[0][0], b[0][0]};
    req_msg[127:64] = {a[1][0], b[1][0]};
    req_val = 2'b11;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (req_val[r] && req_rdy[r]) begin
          n_checks++;
          if (n_iss >= 4 || r != order[n_iss]) begin
            n_fail++;
            $display("FAIL rr_order: issue %0d went to %0d, expected %0d", n_iss, r,
                     (n_iss < 4) ? order[n_iss] : -1);
          end
          n_checks++;
          if (mul_req_msg !== {a[r][k[r]], b[r][k[r]]}) begin
            n_fail++;
            $display("FAIL rr_msg: mul_req_msg=%h expected %h", mul_req_msg,
                     {a[r][k[r]], b[r][k[r]]});
          end
          if (n_iss > 0) begin
            n_checks++;
            if (cyc - last_resp_cyc != 1) begin
              n_fail++;
              $display("FAIL rr_gap: issue %0d cycles after response, expected 1",
                       cyc - last_resp_cyc);
            end
          end
          n_iss++;
          k[r]++;
        end
      end
      if (n_iss == 4 && exp_q.size() == 0) break;
      step();
      for (int r = 0; r < 2; r++) begin
        if (k[r] >= 2) req_val[r] = 1'b0;
        else req_msg[r*64 +: 64] = {a[r][k[r]], b[r][k[r]]};
      end
    end
    req_val = 2'b00;
    n_checks++;
    if (n_iss != 4) begin
      n_fail++;
      $display("FAIL rr_count: %0d issues, expected 4", n_iss);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_stall;
    logic [31:0] a0, b0, a1, b1;
    bit ok;
    apply_reset();
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    resp_rdy = 2'b01;
    req_msg[127:64] = {a1, b1};
    push_exp(1, a1, b1);
    push_exp(0, a0, b0);
    req_val = 2'b10;
    wait_issue(1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_issue1: requester 1 not granted, expected grant");
    end
    step();
    req_val = 2'b01;
    req_msg[63:0] = {a0, b0};
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_val[1]) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_resp_val: resp_val[1]=0, expected 1 within bound");
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (req_rdy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d req_rdy[0]=%b expected 0", i, req_rdy[0]);
      end
      if (i < 9) @(negedge clk);
    end
    step();
    resp_rdy = 2'b11;
    @(negedge clk);
    n_checks++;
    if (req_rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_fire_cycle: req_rdy[0]=%b expected 0", req_rdy[0]);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (req_rdy[0] !== 1'b1 || cyc - last_resp_cyc != 1) begin
      n_fail++;
      $display("FAIL stall_next_issue: req_rdy[0]=%b gap=%0d expected 1 and 1",
               req_rdy[0], cyc - last_resp_cyc);
    end
    step();
    req_val = 2'b00;
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap;
    apply_reset();
    for (int i = 0; i < 4; i++) q4_req_msg[i*64 +: 64] = {32'(i + 1), 32'(100 + i)};
    q4_mul_req_rdy = 1'b1;
    q4_resp_rdy = 4'hF;
    q4_req_val = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (q4_req_rdy !== 4'b1000 || q4_mul_req_msg !== {32'd4, 32'd103}) begin
      n_fail++;
      $display("FAIL wrap_grant3: req_rdy=%b msg=%h expected 1000 and %h",
               q4_req_rdy, q4_mul_req_msg, {32'd4, 32'd103});
    end
    step();
    q4_req_val = 4'b0000;
    q4_mul_resp_val = 1'b1;
    q4_mul_resp_msg = 32'hCAFE0003;
    @(negedge clk);
    n_checks++;
    if (q4_resp_val !== 4'b1000 || q4_resp_msg !== 32'hCAFE0003 || q4_mul_resp_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_resp3: resp_val=%b msg=%h rdy=%b expected 1000 cafe0003 1",
               q4_resp_val, q4_resp_msg, q4_mul_resp_rdy);
    end
    step();
    q4_mul_resp_val = 1'b0;
    q4_req_val = 4'b0101;
    @(negedge clk);
    n_checks++;
    if (q4_req_rdy !== 4'b0001 || q4_mul_req_msg !== {32'd1, 32'd100}) begin
      n_fail++;
      $display("FAIL wrap_grant0: req_rdy=%b msg=%h expected 0001 and %h",
               q4_req_rdy, q4_mul_req_msg, {32'd1, 32'd100});
    end
    step();
    @(negedge clk);
    n_checks++;
    if (q4_req_rdy !== 4'b0000 || q4_mul_req_val !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_busy_ignore: req_rdy=%b mul_req_val=%b expected 0000 0",
               q4_req_rdy, q4_mul_req_val);
    end
    step();
    q4_mul_resp_val = 1'b1;
    @(negedge clk);
    n_checks++;
    if (q4_resp_val !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_resp0: resp_val=%b expected 0001", q4_resp_val);
    end
    step();
    q4_mul_resp_val = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q4_req_rdy !== 4'b0100 || q4_mul_req_msg !== {32'd3, 32'd102}) begin
      n_fail++;
      $display("FAIL wrap_grant2: req_rdy=%b msg=%h expected 0100 and %h",
               q4_req_rdy, q4_mul_req_msg, {32'd3, 32'd102});
    end
    step();
    q4_req_val = 4'b0000;
    q4_mul_resp_val = 1'b1;
    @(negedge clk);
    n_checks++;
    if (q4_resp_val !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_resp2: resp_val=%b expected 0100", q4_resp_val);
    end
    step();
    q4_mul_resp_val = 1'b0;
  endtask

  task automatic test_reset_busy;
    bit ok;
    apply_reset();
    resp_rdy = 2'b11;
    req_msg[63:0] = {32'd3, 32'd5};
    req_val = 2'b01;
    wait_issue(0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstbusy_issue: requester 0 not granted, expected grant");
    end
    step();
    reset = 1'b0;
    req_val = 2'b00;
    @(negedge clk);
    step();
    req_val = 2'b11;
    req_msg[63:0]   = {32'd9, 32'd4};
    req_msg[127:64] = {32'd2, 32'd2};
    @(negedge clk);
    n_checks++;
    if ({req_rdy, resp_val, mul_req_val, mul_resp_rdy} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstbusy_outputs: got %b expected 000000",
               {req_rdy, resp_val, mul_req_val, mul_resp_rdy});
    end
    step();
    reset = 1'b1;
    push_exp(0, 32'd9, 32'd4);
    @(negedge clk);
    n_checks++;
    if (req_rdy !== 2'b01 || mul_req_val !== 1'b1 || mul_req_msg !== {32'd9, 32'd4}) begin
      n_fail++;
      $display("FAIL rstbusy_first_grant: req_rdy=%b val=%b msg=%h expected 01 1 %h",
               req_rdy, mul_req_val, mul_req_msg, {32'd9, 32'd4});
    end
    step();
    req_val = 2'b00;
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstbusy_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
  task automatic test_stats;
    bit ok;
    apply_reset();
    @(negedge clk);
    n_checks++;
    if (stat_issues !== 32'd0 || stat_stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset: issues=%0d stalls=%0d expected 0 0",
               stat_issues, stat_stall_cycles);
    end
    step();
    resp_rdy = 2'b00;
    req_msg[63:0] = {32'd11, 32'd3};
    push_exp(0, 32'd11, 32'd3);
    req_val = 2'b01;
    wait_issue(0, ok);
    step();
    req_val = 2'b10;
    req_msg[127:64] = {32'd5, 32'd5};
    repeat (5) step();
    req_val = 2'b00;
    resp_rdy = 2'b11;
    wait_drain(ok);
    step();
    push_exp(1, 32'd5, 32'd5);
    req_val = 2'b10;
    wait_issue(1, ok);
    step();
    req_val = 2'b00;
    wait_drain(ok);
    step();
    req_msg[63:0] = {32'd2, 32'd8};
    push_exp(0, 32'd2, 32'd8);
    req_val = 2'b01;
    wait_issue(0, ok);
    step();
    req_val = 2'b00;
    wait_drain(ok);
    n_checks++;
    if (stat_issues !== 32'd3 || stat_stall_cycles !== 32'd5) begin
      n_fail++;
      $display("FAIL stats_counts: issues=%0d stalls=%0d expected 3 5",
               stat_issues, stat_stall_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_wrap();
    test_reset_busy();
`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab2_proc_imul_arbiter.md
# lab2_proc_imul_arbiter

Shares one iterative integer multiplier (the lab1 alternative multiplier, 64-bit `{a,b}` request, 32-bit product response) among `p_num_reqs` requesters, e.g. the D stages of several cores or a core plus an accelerator. The block arbitrates round-robin, forwards one request at a time, and routes the product back to the requester that issued it. It sits between the requesters' latency-insensitive val/rdy ports and the multiplier's istream/ostream ports. The multiplier never has more than one operation in flight.

## Interface
- `p_num_reqs`, 2: number of requesters, legal range 2..8.
- `clk`  in  1  clock, all state updates on posedge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `req_val`  in  p_num_reqs  per-requester request valid.
- `req_rdy`  out  p_num_reqs  per-requester request ready.
- `req_msg`  in  64*p_num_reqs  requester i occupies bits [64i+63:64i]; `{a[31:0], b[31:0]}`.
- `resp_val`  out  p_num_reqs  per-requester response valid.
- `resp_rdy`  in  p_num_reqs  per-requester response ready.
- `resp_msg`  out  32  product, broadcast to all requesters; qualified by `resp_val`.
- `mul_req_val` / `mul_req_rdy`  out / in  1 / 1  multiplier istream handshake.
- `mul_req_msg`  out  64  granted requester's `req_msg` slice.
- `mul_resp_val` / `mul_resp_rdy`  in / out  1 / 1  multiplier ostream handshake.
- `mul_resp_msg`  in  32  product from the multiplier.

## Operation
- FSM has two states.
  - IDLE: no operation outstanding.
  - BUSY: one operation is issued and its response has not yet been accepted.
- Pointer `last`, of width clog2(p_num_reqs), holds the index of the most recent winner.
- Grant is computed combinationally in IDLE. It is the first `i` with `req_val[i]=1`, scanning `last+1, last+2, …` modulo p_num_reqs. The scan wraps from p_num_reqs-1 to 0.
- IDLE outputs:
  - `mul_req_val = |req_val`.
  - `mul_req_msg` = slice of the grant.
  - `req_rdy[grant] = mul_req_rdy`; all other bits of `req_rdy` are 0.
  - `resp_val = 0` and `mul_resp_rdy = 0`.
- Issue fire (IDLE, `mul_req_val && mul_req_rdy`): `owner <= grant`, `last <= grant`, go to BUSY.
- BUSY outputs:
  - `req_rdy = 0` and `mul_req_val = 0`.
  - `resp_val[owner] = mul_resp_val`; all other bits of `resp_val` are 0.
  - `mul_resp_rdy = resp_rdy[owner]`.
  - `resp_msg = mul_resp_msg`.
- Response fire (BUSY, `mul_resp_val && resp_rdy[owner]`): go to IDLE.
- `resp_msg` has no width change; it is the low 32 bits of the product exactly as the multiplier delivers it.
- A requester holding `req_val` is granted within p_num_reqs issues (starvation-free).
- Rules at boundary conditions:
  - A requester dropping `req_val` in IDLE before fire gives up its turn. `last` is unchanged.
  - An owner that holds `resp_rdy=0` stalls the shared multiplier. This is legal: other requesters wait and are not timed out.
  - `req_val` and `resp_rdy` from non-owners are ignored in BUSY.
  - The owner may assert `req_val` for its next request while its response fires. That request is considered in the next IDLE cycle.
- Reset (`reset=0` at posedge) goes to IDLE with `last = p_num_reqs-1`, so requester 0 wins first. Reset mid-BUSY drops the outstanding operation. The integrator resets the multiplier with the same (inverted) reset.

## Timing
- Combinational paths:
  - `req_val`/`req_msg` to `mul_req_*`.
  - `mul_req_rdy` to `req_rdy`.
  - `mul_resp_*` to `resp_*`.
  - `resp_rdy` to `mul_resp_rdy`.
- None of these paths loops back on itself.
- The block adds zero cycles of latency: requester latency equals multiplier latency.
- Back-to-back throughput: a new issue can fire in the cycle after a response fire, at the earliest. The bench verifies 1 idle cycle of the multiplier between operations.
- Output values while `reset=0`: `req_rdy=0`, `resp_val=0`, `mul_req_val=0`, `mul_resp_rdy=0`. `mul_req_msg` and `resp_msg` are don't-care.

## Configuration
- `LAB2_PROC_IMUL_ARBITER_STATS_EN`
  - Defined: adds output ports `stat_issues` (32) and `stat_stall_cycles` (32), both cleared by reset.
    - `stat_issues` increments on every issue fire.
    - `stat_stall_cycles` increments on every cycle in which some `req_val[i]=1` and `req_rdy[i]=0`.
    - Both counters wrap 0xFFFFFFFF→0.
  - Undefined: neither port nor its counters exist, and behaviour is otherwise identical.

## Structure
- Package `lab2_proc_imul_arbiter_pkg` contains:
  - The state enum (`IMUL_ARB_IDLE`, `IMUL_ARB_BUSY`).
  - Message widths `c_imul_req_nbits=64` and `c_imul_resp_nbits=32`.
- Sub-module `lab2_proc_imul_rr_grant` is the combinational round-robin priority scan.
  - Inputs: `req_val`, `last`.
  - Outputs: `grant_idx`, `grant_any`.
- The top level holds the FSM, the `owner`/`last` registers, the muxing, and the optional counters.

## Test plan
- Single requester 0 sends `{32'd7,32'd6}`, with a mock multiplier of latency 4 → `resp_val[0]` asserts with `resp_msg=42`; `resp_val[1]` stays 0 throughout.
- Both requesters hold `req_val` continuously for 4 operations → issue order 0,1,0,1; each response is routed only to its own issuer.
- Owner 1 holds `resp_rdy=0` for 10 cycles while requester 0 is pending → `req_rdy[0]=0` for those cycles; requester 0 issues exactly 1 cycle after the response fires.
- With p_num_reqs=4, `last=3` and `req_val=4'b1000` → grant 3 (wrap scan); then with `req_val=4'b0101` → grant 0, then 2.
- `reset=0` asserted mid-BUSY → the next cycle has all outputs 0 and the FSM in IDLE; the first grant after release goes to requester 0.
- With the macro defined, 3 issues plus 5 contested cycles → `stat_issues=3`, `stat_stall_cycles=5`.
